pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Generates clock-enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three conditions: load-use hazards, taken-branch redirects, and variable-latency data-memory accesses.
- Runs a small wait FSM with a timeout, plus a saturating stall-cycle counter for performance monitoring.

Parameters:
- TIMEOUT, 64, number of MEM_WAIT cycles without dmem_ack before the access is abandoned.
- CNT_W, 32, width of the stall_cnt performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_RMEM  in  1  EX instruction is a load.
- ex_WREG  in  1  EX instruction writes the register file.
- ex_nd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_RMEM  in  1  MEM-stage instruction reads data memory.
- mem_WMEM  in  1  MEM-stage instruction writes data memory.
- dmem_ack  in  1  data memory completes the current access this cycle.
- pc_CE  out  1  PC update enable.
- ifid_CE  out  1  IF/ID register enable.
- idex_CE  out  1  ID/EX register enable.
- exmem_CE  out  1  EX/MEM register enable.
- memwb_CE  out  1  MEM/WB register enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- memwb_flush  out  1  load a bubble into MEM/WB.
- dmem_req  out  1  data-memory access request.
- mem_timeout  out  1  sticky flag: a memory access timed out.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_CE=0.

Behaviour:
- States: RUN, MEM_WAIT. There is also a wait counter, wcnt, of width clog2(TIMEOUT+1).
- While rst=1, the block holds:
  - state=RUN, wcnt=0, mem_timeout=0, stall_cnt=0.
  - All CE outputs, flush outputs and dmem_req at 0.
  - Reset is asynchronous; outputs reach these values immediately on assertion.
- Definitions:
  - mem_acc = mem_RMEM | mem_WMEM.
  - load_use = ex_RMEM & ex_WREG & (ex_nd!=0) & ((id_use_rs & id_rs==ex_nd) | (id_use_rt & id_rt==ex_nd)).
- Control outputs are combinational from state and inputs. Priority order, highest first:
  1. Memory wait: state=MEM_WAIT, or (RUN & mem_acc & !dmem_ack).
     - dmem_req=1.
     - pc_CE, ifid_CE, idex_CE and exmem_CE are 0.
     - memwb_CE=1 and memwb_flush=1.
     - ifid_flush=0 and idex_flush=0.
     - Branch and load-use conditions are ignored; they stay pending and are applied on release.
  2. Branch (ex_branch_taken):
     - All CE=1, ifid_flush=1, idex_flush=1.
     - A simultaneous load_use is discarded, because its ID instruction is squashed.
  3. Load-use:
     - pc_CE=0 and ifid_CE=0.
     - idex_CE=1, idex_flush=1.
     - exmem_CE=1, memwb_CE=1.
  4. Otherwise: all CE=1, all flushes 0.
- In RUN, dmem_req = mem_acc.
  - With mem_acc & dmem_ack in the same cycle (zero-wait), no stall occurs and the FSM stays in RUN.
- Transition RUN -> MEM_WAIT on mem_acc & !dmem_ack; wcnt is cleared to 0.
- In MEM_WAIT, each cycle:
  - On dmem_ack: release, i.e. drive the normal RUN-priority outputs for that cycle with the memory condition treated as satisfied, then go to RUN.
  - Otherwise, if wcnt==TIMEOUT-1: set mem_timeout, release the same way, and go to RUN.
  - Otherwise: wcnt increments.
- mem_timeout is cleared only by rst.
- stall_cnt increments on every clock edge where pc_CE=0 and rst=0, and saturates at all ones.
- A dmem_ack arriving in RUN while mem_acc=0 is ignored.
- If rst is asserted mid-wait, the FSM aborts to RUN immediately; the next access re-requests from scratch.

Test Plan:
- Load-use: ex_RMEM=1, ex_WREG=1, ex_nd=5, id_rs=5, id_use_rs=1.
  - Expect pc_CE=0, ifid_CE=0, idex_flush=1, exmem_CE=1 for exactly 1 cycle.
  - stall_cnt goes 0->1.
  - Repeat with ex_nd=0: expect no stall.
- Branch and load-use together in the same cycle:
  - Expect ifid_flush=1, idex_flush=1, pc_CE=1.
  - stall_cnt is unchanged.
- Zero-wait memory: mem_RMEM=1 with dmem_ack=1 in the same cycle.
  - Expect dmem_req=1, all CE=1, state remains RUN.
- 3-cycle memory: mem_WMEM=1, dmem_ack asserted on the 4th cycle.
  - Expect 3 cycles with front CEs=0, memwb_flush=1, dmem_req=1.
  - 4th cycle: all CE=1.
  - stall_cnt=3.
  - A branch asserted during the wait takes effect only on the release cycle.
- Timeout: mem_RMEM=1, dmem_ack never asserted, TIMEOUT=64.
  - Expect release on the 65th cycle of the access and mem_timeout=1.
  - mem_timeout stays 1 until rst.
- Asynchronous reset mid-wait: assert rst between edges during MEM_WAIT.
  - Expect all outputs 0 immediately, without waiting for a clock edge.
  - After release, a pending access re-enters MEM_WAIT with wcnt=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-control bundle between the 5-stage core datapath and its stall/flush sequencer.
// master = datapath side (hazard sources), slave = pipe_stall_ctrl.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_RMEM;
  logic             ex_WREG;
  logic [4:0]       ex_nd;
  logic             ex_branch_taken;
  logic             mem_RMEM;
  logic             mem_WMEM;
  logic             dmem_ack;
  logic             pc_CE;
  logic             ifid_CE;
  logic             idex_CE;
  logic             exmem_CE;
  logic             memwb_CE;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_flush;
  logic             dmem_req;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_RMEM, ex_WREG, ex_nd,
           ex_branch_taken, mem_RMEM, mem_WMEM, dmem_ack,
    input  pc_CE, ifid_CE, idex_CE, exmem_CE, memwb_CE, ifid_flush,
           idex_flush, memwb_flush, dmem_req, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_RMEM, ex_WREG, ex_nd,
           ex_branch_taken, mem_RMEM, mem_WMEM, dmem_ack,
    output pc_CE, ifid_CE, idex_CE, exmem_CE, memwb_CE, ifid_flush,
           idex_flush, memwb_flush, dmem_req, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: register enables/flushes for load-use, branch redirect and
// variable-latency data memory, with a wait timeout and a stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_ctrl_if.slave  ctrl
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic mem_acc;
  logic load_use;
  logic mem_stall;
  logic pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce;
  logic ifid_fl, idex_fl, memwb_fl, req;

  assign mem_acc  = ctrl.mem_RMEM | ctrl.mem_WMEM;
  assign load_use = ctrl.ex_RMEM & ctrl.ex_WREG & (ctrl.ex_nd != 5'd0) &
                    ((ctrl.id_use_rs & (ctrl.id_rs == ctrl.ex_nd)) |
                     (ctrl.id_use_rt & (ctrl.id_rt == ctrl.ex_nd)));

  // In MEM_WAIT, an ack or the last timeout cycle is a release cycle, not a stall.
  assign mem_stall = (state_q == MEM_WAIT) ? (!ctrl.dmem_ack && (wcnt_q != WCNT_LAST))
                                           : (mem_acc && !ctrl.dmem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      RUN: begin
        if (mem_acc && !ctrl.dmem_ack) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (ctrl.dmem_ack) begin
          state_d = RUN;
        end else if (wcnt_q == WCNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = RUN;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    if (!pc_ce && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_ce    = 1'b0;
    ifid_ce  = 1'b0;
    idex_ce  = 1'b0;
    exmem_ce = 1'b0;
    memwb_ce = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    memwb_fl = 1'b0;
    req      = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        req      = 1'b1;
        memwb_ce = 1'b1;
        memwb_fl = 1'b1;
      end else begin
        req = mem_acc;
        if (ctrl.ex_branch_taken) begin
          pc_ce    = 1'b1;
          ifid_ce  = 1'b1;
          idex_ce  = 1'b1;
          exmem_ce = 1'b1;
          memwb_ce = 1'b1;
          ifid_fl  = 1'b1;
          idex_fl  = 1'b1;
        end else if (load_use) begin
          idex_ce  = 1'b1;
          idex_fl  = 1'b1;
          exmem_ce = 1'b1;
          memwb_ce = 1'b1;
        end else begin
          pc_ce    = 1'b1;
          ifid_ce  = 1'b1;
          idex_ce  = 1'b1;
          exmem_ce = 1'b1;
          memwb_ce = 1'b1;
        end
      end
    end
  end

  assign ctrl.pc_CE       = pc_ce;
  assign ctrl.ifid_CE     = ifid_ce;
  assign ctrl.idex_CE     = idex_ce;
  assign ctrl.exmem_CE    = exmem_ce;
  assign ctrl.memwb_CE    = memwb_ce;
  assign ctrl.ifid_flush  = ifid_fl;
  assign ctrl.idex_flush  = idex_fl;
  assign ctrl.memwb_flush = memwb_fl;
  assign ctrl.dmem_req    = req;
  assign ctrl.mem_timeout = timeout_q;
  assign ctrl.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized and directed bench for pipe_stall_ctrl against an access-cycle-index model.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_flush, dmem_req}
  logic [8:0] dut_v;
  assign dut_v = {bus.pc_CE, bus.ifid_CE, bus.idex_CE, bus.exmem_CE, bus.memwb_CE,
                  bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.dmem_req};

  // Model state: 1-based index of the last stalled cycle of the access in flight (0 = none).
  int               m_acc;
  logic             m_to;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.ex_RMEM = 1'b0; bus.ex_WREG = 1'b0; bus.ex_nd = 5'd0; bus.ex_branch_taken = 1'b0;
    bus.mem_RMEM = 1'b0; bus.mem_WMEM = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  // Assert reset between edges and check the outputs clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_acc = 0; m_to = 1'b0; m_cnt = '0;
    chk("rst_ctl", 64'(dut_v), 64'd0);
    chk("rst_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_to", 64'(bus.mem_timeout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic step();
    int k;
    bit engaged, stall, tev, lu, macc;
    logic [8:0] exp_v;
    @(negedge clk);
    macc    = bus.mem_RMEM || bus.mem_WMEM;
    k       = (m_acc > 0) ? m_acc + 1 : 1;
    engaged = (m_acc > 0) || macc;
    stall   = engaged && !bus.dmem_ack && (k <= int'(TIMEOUT));
    tev     = engaged && !bus.dmem_ack && (k > int'(TIMEOUT));
    lu      = bus.ex_RMEM && bus.ex_WREG && (bus.ex_nd != 0) &&
              ((bus.id_use_rs && bus.id_rs == bus.ex_nd) ||
               (bus.id_use_rt && bus.id_rt == bus.ex_nd));
    if (stall)                    exp_v = 9'b00001_001_1;
    else if (bus.ex_branch_taken) exp_v = {8'b11111_110, macc};
    else if (lu)                  exp_v = {8'b00111_010, macc};
    else                          exp_v = {8'b11111_000, macc};
    chk("ctl", 64'(dut_v), 64'(exp_v));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    chk("mem_timeout", 64'(bus.mem_timeout), 64'(m_to));
    @(posedge clk);
    m_acc = stall ? k : 0;
    if (tev) m_to = 1'b1;
    if (!exp_v[8] && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    set_idle();
    do_reset();

    // Load-use on r5: one-cycle stall.
    bus.ex_RMEM = 1'b1; bus.ex_WREG = 1'b1; bus.ex_nd = 5'd5;
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    step();
    chk("lu_cnt", 64'(bus.stall_cnt), 64'd1);
    // Same pattern targeting r0: no hazard.
    bus.ex_nd = 5'd0; bus.id_rs = 5'd0;
    step();
    chk("lu_r0_cnt", 64'(bus.stall_cnt), 64'd1);
    // Branch together with load-use: branch wins, no stall.
    bus.ex_nd = 5'd7; bus.id_rt = 5'd7; bus.id_use_rt = 1'b1; bus.id_use_rs = 1'b0;
    bus.ex_branch_taken = 1'b1;
    step();
    chk("br_lu_cnt", 64'(bus.stall_cnt), 64'd1);
    // Zero-wait memory access.
    set_idle();
    bus.mem_RMEM = 1'b1; bus.dmem_ack = 1'b1;
    step();
    chk("zw_cnt", 64'(bus.stall_cnt), 64'd1);

    // Three-cycle store with a branch raised mid-wait.
    set_idle();
    do_reset();
    bus.mem_WMEM = 1'b1;
    step();
    bus.ex_branch_taken = 1'b1;
    step();
    step();
    bus.dmem_ack = 1'b1;
    step();
    chk("mem3_cnt", 64'(bus.stall_cnt), 64'd3);
    set_idle();
    step();

    // Reset mid-wait, then a fresh access runs to timeout with the full budget.
    bus.mem_RMEM = 1'b1;
    step();
    step();
    step();
    do_reset();
    for (int i = 0; i < int'(TIMEOUT) + 1; i++) step();
    chk("to_flag", 64'(bus.mem_timeout), 64'd1);
    chk("to_cnt", 64'(bus.stall_cnt), 64'(TIMEOUT));
    set_idle();
    step();
    step();
    chk("to_sticky", 64'(bus.mem_timeout), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.id_use_rs       = ($urandom_range(0, 1) == 1);
      bus.id_use_rt       = ($urandom_range(0, 1) == 1);
      bus.ex_RMEM         = ($urandom_range(0, 1) == 1);
      bus.ex_WREG         = ($urandom_range(0, 3) != 0);
      bus.ex_nd           = 5'($urandom_range(0, 3));
      bus.ex_branch_taken = ($urandom_range(0, 4) == 0);
      bus.mem_RMEM        = ($urandom_range(0, 5) == 0);
      bus.mem_WMEM        = ($urandom_range(0, 7) == 0);
      bus.dmem_ack        = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
